// File: rtl/hs_pkg.sv
// Shared definitions for the four-phase req/ack handshake responder.
package hs_pkg;

  // Responder handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } hs_state_e;

endpackage : hs_pkg

// File: rtl/hs_if.sv
// Shared four-phase handshake interface. An initiator drives req/req_data
// through the clocking block, so they reach the responder one cycle after
// the initiator's decision edge.
interface hs_if #(
  parameter int DATA_W = 8
) (
  input logic clk
);

  logic              req;
  logic [DATA_W-1:0] req_data;
  logic              ack;

  clocking cb @(posedge clk);
    output req;
    output req_data;
    input  ack;
  endclocking

  modport initiator (clocking cb, input clk);
  modport responder (input clk, input req, input req_data, output ack);

endinterface : hs_if

// File: rtl/hs_resp_fifo.sv
// Synchronous show-ahead FIFO buffering acknowledged payloads.
// A push while full is taken only together with a pop on the same edge.
module hs_resp_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              wr_en_s;
  logic              rd_en_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];

  // Qualify requests: never overwrite unread data, never pop an empty FIFO.
  always_comb begin
    wr_en_s = push && (!full || pop);
    rd_en_s = pop && !empty;
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers (wrap naturally) and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule : hs_resp_fifo

// File: rtl/hs_responder.sv
// Responder end of the four-phase req/ack handshake: registers a request,
// waits RESP_LAT cycles, buffers the payload and acknowledges; buffered
// payloads drain over a valid/ready port.
module hs_responder
  import hs_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int RESP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              proto_err
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WCNT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  hs_state_e         state_r;
  hs_state_e         state_next_s;
  logic [WCNT_W-1:0] wait_cnt_r;
  logic [WCNT_W-1:0] wait_cnt_next_s;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] hold_next_s;
  logic              ack_r;
  logic              ack_next_s;
  logic              proto_err_r;
  logic              proto_err_next_s;
  logic              push_s;
  logic              pop_s;
  logic              push_ok_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [DATA_W-1:0] fifo_head_s;

  assign pop_s     = !fifo_empty_s && rsp_ready;
  // The occupancy compare backs up the full flag; a same-edge pop frees a slot.
  assign push_ok_s = (!fifo_full_s && (fifo_count_s < CNT_W'(DEPTH))) || pop_s;

  assign ack       = ack_r;
  assign proto_err = proto_err_r;
  assign rsp_valid = !fifo_empty_s;
  assign rsp_data  = fifo_head_s;

  hs_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (hold_r),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Handshake next-state, wait counter, hold register and push decision.
  always_comb begin
    state_next_s     = state_r;
    wait_cnt_next_s  = wait_cnt_r;
    hold_next_s      = hold_r;
    ack_next_s       = ack_r;
    proto_err_next_s = 1'b0;
    push_s           = 1'b0;
    case (state_r)
      IDLE: begin
        ack_next_s = 1'b0;
        if (req) begin
          hold_next_s     = req_data;
          wait_cnt_next_s = WCNT_W'(RESP_LAT - 1);
          state_next_s    = WAIT;
        end else begin
          state_next_s    = IDLE;
        end
      end
      WAIT: begin
        if (!req) begin
          proto_err_next_s = 1'b1;
          hold_next_s      = DATA_W'(0);
          wait_cnt_next_s  = WCNT_W'(0);
          state_next_s     = IDLE;
        end else if (wait_cnt_r != WCNT_W'(0)) begin
          wait_cnt_next_s  = wait_cnt_r - WCNT_W'(1);
        end else if (push_ok_s) begin
          push_s           = 1'b1;
          ack_next_s       = 1'b1;
          state_next_s     = ACK;
        end else begin
          state_next_s     = WAIT;
        end
      end
      ACK: begin
        if (!req) begin
          ack_next_s   = 1'b0;
          state_next_s = IDLE;
        end else begin
          ack_next_s   = 1'b1;
        end
      end
      default: begin
        ack_next_s   = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // Handshake state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= WCNT_W'(0);
      hold_r      <= DATA_W'(0);
      ack_r       <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      wait_cnt_r  <= wait_cnt_next_s;
      hold_r      <= hold_next_s;
      ack_r       <= ack_next_s;
      proto_err_r <= proto_err_next_s;
    end
  end

endmodule : hs_responder

// File: tb/tb_hs_responder.sv
// Scoreboard bench for hs_responder: expected payloads are queued when a
// request is issued; a negedge monitor compares every accepted FIFO head.
module tb_hs_responder;
  import hs_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LAT    = 2;
  localparam int LAT3   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, rsp_ready;
  logic [7:0]  req_data;
  logic        ack, rsp_valid, proto_err;
  logic [7:0]  rsp_data;
  logic        req3, rsp_ready3;
  logic [7:0]  req_data3;
  logic        ack3, rsp_valid3, proto_err3;
  logic [7:0]  rsp_data3;

  int          pass_cnt   = 0;
  int          total_cnt  = 0;
  int          acks_done  = 0;
  int          pops_seen  = 0;
  int          pops_base  = 0;
  int          perr_cnt   = 0;
  bit          rand_ready = 1'b0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  hs_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RESP_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .proto_err(proto_err)
  );

  hs_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RESP_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_data(req_data3), .ack(ack3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_ready(rsp_ready3),
    .proto_err(proto_err3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every accepted head must match the oldest queued payload.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pop: got %0h expected no data", rsp_data);
      end else begin
        check("rsp_data", rsp_data, exp_q.pop_front());
      end
      pops_seen++;
    end
    if (proto_err) perr_cnt++;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // One full handshake on the main DUT; checks ack latency when room exists.
  task automatic hs(input logic [7:0] d);
    int n;
    int occ;
    bit room;
    req = 1'b1;
    req_data = d;
    exp_q.push_back(d);
    tick();
    req_data = ~d;
    n = 0;
    room = 1'b1;
    while (ack !== 1'b1 && n < 40) begin
      if (n == LAT - 1) begin
        occ  = acks_done - (pops_seen - pops_base);
        room = (occ < DEPTH) || (rsp_ready && occ > 0);
      end
      tick();
      n++;
    end
    if (n >= 40) begin
      total_cnt++;
      $display("FAIL ack_timeout: got no ack expected ack for %0h", d);
    end else begin
      acks_done++;
      if (room) check("ack_latency", n, LAT);
    end
    req = 1'b0;
    tick();
    check("ack_drop", ack, 1'b0);
  endtask

  task automatic drain();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("drain_queue_left", exp_q.size(), 0);
    check("drain_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    bit ack3_seen;
    int n;
    rst = 1'b1; req = 1'b0; req_data = 8'h00; rsp_ready = 1'b0;
    req3 = 1'b0; req_data3 = 8'h00; rsp_ready3 = 1'b0;
    repeat (3) tick();
    check("rst_ack", ack, 1'b0);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_perr", proto_err, 1'b0);
    check("rst_ack3", ack3, 1'b0);
    rst = 1'b0;
    tick();

    // Single transfer with rsp_ready high.
    rsp_ready = 1'b1;
    req = 1'b1; req_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    req_data = 8'h3C;
    check("t1_ack_n", ack, 1'b0);
    tick();
    check("t1_ack_n1", ack, 1'b0);
    tick();
    check("t1_ack_n2", ack, 1'b1);
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_data", rsp_data, 8'hA5);
    acks_done++;
    tick();
    check("t1_ack_held", ack, 1'b1);
    check("t1_popped", rsp_valid, 1'b0);
    req = 1'b0;
    tick();
    check("t1_ack_low", ack, 1'b0);

    // Back-to-back with rsp_ready low: fifth request stalls until a pop.
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) hs(8'(i));
    check("full_count", u_dut.fifo_count_s, DEPTH);
    req = 1'b1; req_data = 8'h05; exp_q.push_back(8'h05);
    tick();
    req_data = 8'hEE;
    repeat (5) tick();
    check("stall_ack", ack, 1'b0);
    check("stall_state", u_dut.state_r, WAIT);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("unstall_ack", ack, 1'b1);
    check("unstall_count", u_dut.fifo_count_s, DEPTH);
    acks_done++;
    req = 1'b0;
    tick();
    check("unstall_ack_drop", ack, 1'b0);
    drain();

    // Reset while in ACK with two entries buffered.
    rsp_ready = 1'b0;
    hs(8'h11);
    req = 1'b1; req_data = 8'h22; exp_q.push_back(8'h22);
    repeat (3) tick();
    check("pre_rst_ack", ack, 1'b1);
    check("pre_rst_count", u_dut.fifo_count_s, 2);
    rst = 1'b1;
    tick();
    check("mid_rst_ack", ack, 1'b0);
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_state", u_dut.state_r, IDLE);
    check("mid_rst_perr", proto_err, 1'b0);
    exp_q.delete();
    acks_done = 0;
    pops_base = pops_seen;
    req = 1'b0;
    rst = 1'b0;
    tick();

    // Abort on the RESP_LAT=3 instance: req high one edge, then low.
    ack3_seen = 1'b0;
    req3 = 1'b1; req_data3 = 8'h5A;
    tick();
    ack3_seen |= ack3;
    req3 = 1'b0;
    tick();
    ack3_seen |= ack3;
    check("abort_perr_pulse", proto_err3, 1'b1);
    tick();
    ack3_seen |= ack3;
    check("abort_perr_end", proto_err3, 1'b0);
    repeat (4) begin
      tick();
      ack3_seen |= ack3;
    end
    check("abort_no_ack", ack3_seen, 1'b0);
    check("abort_no_push", rsp_valid3, 1'b0);

    // Normal transfer on the RESP_LAT=3 instance.
    req3 = 1'b1; req_data3 = 8'hC3;
    tick();
    req_data3 = 8'h00;
    n = 0;
    while (ack3 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("lat3_latency", n, LAT3);
    check("lat3_data", rsp_data3, 8'hC3);
    check("lat3_valid", rsp_valid3, 1'b1);
    req3 = 1'b0;
    tick();
    check("lat3_ack_drop", ack3, 1'b0);

    // Random payloads with random downstream readiness.
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) hs(8'($urandom_range(0, 255)));
    rand_ready = 1'b0;
    drain();
    check("main_no_proto_err", perr_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_hs_responder
